// File: rtl/note_controller.sv
// Keyboard note controller: synchronizes and debounces 13 keys and two buttons,
// picks the lowest pressed key, and gates it through a small retrigger FSM.

module note_debounce #(
  parameter int          W  = 1,
  parameter logic [15:0] DB = 16'd10000
) (
  input  logic         clk,
  input  logic         n_rst,
  input  logic [W-1:0] raw,
  output logic [W-1:0] stable
);
  logic [W-1:0] s1, s2, prev;
  logic [15:0]  cnt;

  // prev tracks the last synchronized value; it must hold DB cycles before acceptance
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      s1     <= '0;
      s2     <= '0;
      prev   <= '0;
      cnt    <= '0;
      stable <= '0;
    end else begin
      s1 <= raw;
      s2 <= s1;
      if (s2 != prev) begin
        prev <= s2;
        cnt  <= '0;
      end else if (cnt != DB - 16'd1) begin
        cnt <= cnt + 16'd1;
      end else begin
        stable <= prev;
      end
    end
  end
endmodule

module note_controller #(
  parameter logic [15:0] DB_CYCLES = 16'd10000
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic [12:0] keys,
  input  logic        pb_mode,
  input  logic        pb_sound,
  output logic [3:0]  note,
  output logic        gate,
  output logic        note_on,
  output logic        note_off,
  output logic [1:0]  mode,
  output logic        sound
);
  typedef enum logic [1:0] {IDLE, HOLD, RETRIG} state_t;

  logic [12:0] stable_keys;
  logic        mode_db, sound_db, mode_db_d, sound_db_d;
  logic [3:0]  code;
  state_t      state, state_n;
  logic [3:0]  note_n;
  logic        gate_n, on_n, off_n;

  note_debounce #(.W(13), .DB(DB_CYCLES)) u_db_keys (
    .clk(clk), .n_rst(n_rst), .raw(keys), .stable(stable_keys));
  note_debounce #(.W(1), .DB(DB_CYCLES)) u_db_mode (
    .clk(clk), .n_rst(n_rst), .raw(pb_mode), .stable(mode_db));
  note_debounce #(.W(1), .DB(DB_CYCLES)) u_db_sound (
    .clk(clk), .n_rst(n_rst), .raw(pb_sound), .stable(sound_db));

  // Lowest key wins: scan downward so the last hit is the lowest index
  always_comb begin
    code = 4'hF;
    for (int i = 12; i >= 0; i--)
      if (stable_keys[i]) code = 4'(i);
  end

  always_comb begin
    state_n = state;
    note_n  = note;
    gate_n  = gate;
    on_n    = 1'b0;
    off_n   = 1'b0;
    case (state)
      IDLE: begin
        if (code != 4'hF) begin
          note_n  = code;
          gate_n  = 1'b1;
          on_n    = 1'b1;
          state_n = HOLD;
        end else begin
          note_n = 4'hF;
          gate_n = 1'b0;
        end
      end
      HOLD: begin
        if (code == 4'hF) begin
          note_n  = 4'hF;
          gate_n  = 1'b0;
          off_n   = 1'b1;
          state_n = IDLE;
        end else if (code != note) begin
          // note keeps the old value for the gate-low gap
          gate_n  = 1'b0;
          off_n   = 1'b1;
          state_n = RETRIG;
        end
      end
      RETRIG: begin
        if (code == 4'hF) begin
          note_n  = 4'hF;
          gate_n  = 1'b0;
          state_n = IDLE;
        end else begin
          note_n  = code;
          gate_n  = 1'b1;
          on_n    = 1'b1;
          state_n = HOLD;
        end
      end
      default: begin
        note_n  = 4'hF;
        gate_n  = 1'b0;
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state      <= IDLE;
      note       <= 4'hF;
      gate       <= 1'b0;
      note_on    <= 1'b0;
      note_off   <= 1'b0;
      mode       <= 2'd0;
      sound      <= 1'b0;
      mode_db_d  <= 1'b0;
      sound_db_d <= 1'b0;
    end else begin
      state      <= state_n;
      note       <= note_n;
      gate       <= gate_n;
      note_on    <= on_n;
      note_off   <= off_n;
      mode_db_d  <= mode_db;
      sound_db_d <= sound_db;
      if (mode_db && !mode_db_d)   mode  <= mode + 2'd1;
      if (sound_db && !sound_db_d) sound <= ~sound;
    end
  end
endmodule

// File: tb/tb_note_controller.sv
// Directed bench for note_controller with DB_CYCLES=4 (key/button latency 7 edges).

module tb_note_controller;
  logic        clk = 1'b0;
  logic        n_rst;
  logic [12:0] keys;
  logic        pb_mode, pb_sound;
  logic [3:0]  note;
  logic        gate, note_on, note_off;
  logic [1:0]  mode;
  logic        sound;

  int n_chk = 0;
  int n_fail = 0;

  note_controller #(.DB_CYCLES(16'd4)) dut (
    .clk(clk), .n_rst(n_rst), .keys(keys), .pb_mode(pb_mode), .pb_sound(pb_sound),
    .note(note), .gate(gate), .note_on(note_on), .note_off(note_off),
    .mode(mode), .sound(sound));

  always #5 clk = ~clk;

  // Advance one rising edge and sample 1ns later
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset;
    n_rst = 1'b0; keys = '0; pb_mode = 1'b0; pb_sound = 1'b0;
    tick(2);
    n_chk++;
    if ({note, gate, note_on, note_off, mode, sound} !== {4'hF, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset: note=%h gate=%b on=%b off=%b mode=%0d sound=%b exp F/0/0/0/0/0",
               note, gate, note_on, note_off, mode, sound);
    end
    n_rst = 1'b1;
    tick(10);
    n_chk++;
    if ({note, gate} !== {4'hF, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_idle: note=%h gate=%b exp F/0", note, gate);
    end
  endtask

  task automatic test_single;
    keys = 13'h0010;
    tick(7);
    n_chk++;
    if ({gate, note_on} !== 2'b00) begin
      n_fail++;
      $display("FAIL single_early: gate=%b on=%b at edge 6 exp 0/0", gate, note_on);
    end
    tick();
    n_chk++;
    if ({note, gate, note_on, note_off} !== {4'd4, 1'b1, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL single_on: note=%0d gate=%b on=%b off=%b exp 4/1/1/0", note, gate, note_on, note_off);
    end
    tick();
    n_chk++;
    if ({note, gate, note_on} !== {4'd4, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL single_pulse: note=%0d gate=%b on=%b exp 4/1/0", note, gate, note_on);
    end
    keys = '0;
    tick(7);
    n_chk++;
    if ({gate, note_off} !== 2'b10) begin
      n_fail++;
      $display("FAIL release_early: gate=%b off=%b at edge 6 exp 1/0", gate, note_off);
    end
    tick();
    n_chk++;
    if ({note, gate, note_on, note_off} !== {4'hF, 1'b0, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL release_off: note=%h gate=%b on=%b off=%b exp F/0/0/1", note, gate, note_on, note_off);
    end
    tick();
    n_chk++;
    if (note_off !== 1'b0) begin
      n_fail++;
      $display("FAIL release_pulse: off=%b exp 0", note_off);
    end
    tick(4);
  endtask

  task automatic test_retrig;
    keys = 13'h0210;
    tick(8);
    n_chk++;
    if ({note, gate, note_on} !== {4'd4, 1'b1, 1'b1}) begin
      n_fail++;
      $display("FAIL prio_on: note=%0d gate=%b on=%b exp 4/1/1", note, gate, note_on);
    end
    tick(3);
    keys = 13'h0200;
    tick(7);
    n_chk++;
    if ({note, gate, note_off} !== {4'd4, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL retrig_early: note=%0d gate=%b off=%b exp 4/1/0", note, gate, note_off);
    end
    tick();
    n_chk++;
    if ({note, gate, note_on, note_off} !== {4'd4, 1'b0, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL retrig_off: note=%0d gate=%b on=%b off=%b exp 4/0/0/1", note, gate, note_on, note_off);
    end
    tick();
    n_chk++;
    if ({note, gate, note_on, note_off} !== {4'd9, 1'b1, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL retrig_on: note=%0d gate=%b on=%b off=%b exp 9/1/1/0", note, gate, note_on, note_off);
    end
    keys = '0;
    tick(8);
    n_chk++;
    if ({note, gate, note_off} !== {4'hF, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL retrig_release: note=%h gate=%b off=%b exp F/0/1", note, gate, note_off);
    end
    tick(4);
  endtask

  task automatic test_glitch;
    keys = 13'h0001;
    tick(3);
    keys = '0;
    for (int i = 0; i < 12; i++) begin
      tick();
      n_chk++;
      if ({gate, note_on, note} !== {1'b0, 1'b0, 4'hF}) begin
        n_fail++;
        $display("FAIL glitch[%0d]: gate=%b on=%b note=%h exp 0/0/F", i, gate, note_on, note);
      end
    end
  endtask

  task automatic test_mode;
    logic [1:0] exp_m;
    for (int p = 0; p < 4; p++) begin
      exp_m = 2'(p + 1);
      pb_mode = 1'b1;
      tick(7);
      n_chk++;
      if (mode !== 2'(p)) begin
        n_fail++;
        $display("FAIL mode_early[%0d]: mode=%0d exp %0d", p, mode, p);
      end
      tick(3);
      n_chk++;
      if (mode !== exp_m) begin
        n_fail++;
        $display("FAIL mode_press[%0d]: mode=%0d exp %0d", p, mode, exp_m);
      end
      pb_mode = 1'b0;
      tick(10);
    end
    pb_mode = 1'b1; pb_sound = 1'b1;
    tick(7);
    n_chk++;
    if ({mode, sound} !== {2'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL both_early: mode=%0d sound=%b exp 0/0", mode, sound);
    end
    tick();
    n_chk++;
    if ({mode, sound, gate, note_on} !== {2'd1, 1'b1, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL both_edge: mode=%0d sound=%b gate=%b on=%b exp 1/1/0/0", mode, sound, gate, note_on);
    end
    tick(12);
    n_chk++;
    if ({mode, sound} !== {2'd1, 1'b1}) begin
      n_fail++;
      $display("FAIL both_held: mode=%0d sound=%b exp 1/1", mode, sound);
    end
    pb_mode = 1'b0; pb_sound = 1'b0;
    tick(10);
  endtask

  task automatic test_reset_hold;
    keys = 13'h0080;
    tick(8);
    n_chk++;
    if ({note, gate, note_on} !== {4'd7, 1'b1, 1'b1}) begin
      n_fail++;
      $display("FAIL rh_on: note=%0d gate=%b on=%b exp 7/1/1", note, gate, note_on);
    end
    tick(2);
    n_rst = 1'b0;
    tick();
    n_rst = 1'b1;
    n_chk++;
    if ({note, gate, note_on, note_off, mode, sound} !== {4'hF, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL rh_reset: note=%h gate=%b on=%b off=%b mode=%0d sound=%b exp F/0/0/0/0/0",
               note, gate, note_on, note_off, mode, sound);
    end
    for (int i = 0; i < 7; i++) begin
      tick();
      n_chk++;
      if ({gate, note_on, note_off} !== 3'b000) begin
        n_fail++;
        $display("FAIL rh_wait[%0d]: gate=%b on=%b off=%b exp 0/0/0", i, gate, note_on, note_off);
      end
    end
    tick();
    n_chk++;
    if ({note, gate, note_on, note_off} !== {4'd7, 1'b1, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL rh_restart: note=%0d gate=%b on=%b off=%b exp 7/1/1/0", note, gate, note_on, note_off);
    end
    keys = '0;
    tick(10);
  endtask

  initial begin
    test_reset();
    test_single();
    test_retrig();
    test_glitch();
    test_mode();
    test_reset_hold();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
